// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game sequencer: state encoding and parameter defaults.
package breakout_pkg;

  localparam logic [2:0] ST_NEWGAME = 3'd0;
  localparam logic [2:0] ST_PLAY    = 3'd1;
  localparam logic [2:0] ST_NEWBALL = 3'd2;
  localparam logic [2:0] ST_OVER    = 3'd3;
  localparam logic [2:0] ST_WIN     = 3'd4;

  typedef enum logic [2:0] {
    StNewGame = ST_NEWGAME,
    StPlay    = ST_PLAY,
    StNewBall = ST_NEWBALL,
    StOver    = ST_OVER,
    StWin     = ST_WIN
  } state_e;

  localparam int unsigned NUM_BALLS_DEFAULT     = 3;
  localparam int unsigned TIMEOUT_TICKS_DEFAULT = 120;

endpackage

// File: rtl/breakout_game_ctrl_if.sv
// Signals between the game sequencer, the graphics engine and the text overlay.
interface breakout_game_ctrl_if;
  logic [4:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic       all_cleared;
  logic       gra_still;
  logic [2:0] game_state;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] balls_left;
  logic       timer_up;

  modport master (
    output btn, refr_tick, hit, miss, all_cleared,
    input  gra_still, game_state, score_d1, score_d0, balls_left, timer_up
  );

  modport slave (
    input  btn, refr_tick, hit, miss, all_cleared,
    output gra_still, game_state, score_d1, score_d0, balls_left, timer_up
  );
endinterface

// File: rtl/breakout_game_ctrl_bcd2_counter.sv
// Two-digit BCD counter that saturates at 99; clr has priority over inc.
module bcd2_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  logic [3:0] d1_q;
  logic [3:0] d0_q;
  logic       at_max;

  assign at_max = (d1_q == 4'd9) && (d0_q == 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1_q <= 4'd0;
      d0_q <= 4'd0;
    end else if (clr) begin
      d1_q <= 4'd0;
      d0_q <= 4'd0;
    end else if (inc && !at_max) begin
      if (d0_q == 4'd9) begin
        d0_q <= 4'd0;
        d1_q <= d1_q + 4'd1;
      end else begin
        d0_q <= d0_q + 4'd1;
      end
    end
  end

  assign d1 = d1_q;
  assign d0 = d0_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: FSM, balls counter, refresh-tick delay timer and BCD score.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned NUM_BALLS     = NUM_BALLS_DEFAULT,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  breakout_game_ctrl_if.slave bus
);

  localparam int unsigned       TimerW    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(TIMEOUT_TICKS);
  localparam logic [1:0]        BallsInit = 2'(NUM_BALLS);

  state_e            state_q;
  logic [1:0]        balls_q;
  logic [TimerW-1:0] timer_q;
  logic              still_q;

  logic start;
  logic timer_zero;
  logic score_clr;
  logic score_inc;

  assign start      = |bus.btn;
  assign timer_zero = (timer_q == '0);
  assign score_clr  = (state_q == StNewGame) && start;
  assign score_inc  = (state_q == StPlay) && bus.hit;

  bcd2_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .d1    (bus.score_d1),
    .d0    (bus.score_d0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StNewGame;
      balls_q <= BallsInit;
      timer_q <= '0;
      still_q <= 1'b1;
    end else begin
      // Loads below override this decrement on state entry.
      if (bus.refr_tick && !timer_zero) begin
        timer_q <= timer_q - 1'b1;
      end
      case (state_q)
        StNewGame: begin
          if (start) begin
            state_q <= StPlay;
            balls_q <= BallsInit;
            still_q <= 1'b0;
          end
        end
        StPlay: begin
          if (bus.all_cleared) begin
            state_q <= StWin;
            timer_q <= TimerLoad;
            still_q <= 1'b1;
          end else if (bus.miss) begin
            timer_q <= TimerLoad;
            still_q <= 1'b1;
            if (balls_q == 2'd1) begin
              balls_q <= 2'd0;
              state_q <= StOver;
            end else begin
              balls_q <= balls_q - 2'd1;
              state_q <= StNewBall;
            end
          end
        end
        StNewBall: begin
          if (timer_zero && start) begin
            state_q <= StPlay;
            still_q <= 1'b0;
          end
        end
        StOver, StWin: begin
          if (timer_zero) begin
            state_q <= StNewGame;
          end
        end
        default: begin
          state_q <= StNewGame;
          still_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.game_state = state_q;
  assign bus.gra_still  = still_q;
  assign bus.balls_left = balls_q;
  assign bus.timer_up   = timer_zero;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed, table-driven bench for the breakout game sequencer.
module tb_breakout_game_ctrl;
  import breakout_pkg::*;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  int   exp_score;

  breakout_game_ctrl_if bus ();

  breakout_game_ctrl #(
    .NUM_BALLS     (3),
    .TIMEOUT_TICKS (120)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;
    logic       hit;
    logic       miss;
    logic       ac;
    logic       tick;
    logic [2:0] st;
    int         score;
    logic [1:0] balls;
    logic       still;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_out(input string tag, input logic [2:0] st, input int score,
                           input logic [1:0] balls, input logic still);
    check({tag, ".state"}, 32'(bus.game_state), 32'(st));
    check({tag, ".d1"}, 32'(bus.score_d1), 32'(score / 10));
    check({tag, ".d0"}, 32'(bus.score_d0), 32'(score % 10));
    check({tag, ".balls"}, 32'(bus.balls_left), 32'(balls));
    check({tag, ".still"}, 32'(bus.gra_still), 32'(still));
  endtask

  task automatic step(input logic [4:0] b, input logic h, input logic m, input logic a,
                      input logic t);
    bus.btn = b;
    bus.hit = h;
    bus.miss = m;
    bus.all_cleared = a;
    bus.refr_tick = t;
    @(posedge clk);
    #1;
    bus.btn = '0;
    bus.hit = 1'b0;
    bus.miss = 1'b0;
    bus.all_cleared = 1'b0;
    bus.refr_tick = 1'b0;
  endtask

  // Each iteration ends on the tick edge, so a zero timer never gets an extra idle cycle.
  task automatic run_ticks(input int n, input logic [4:0] b);
    for (int i = 0; i < n; i++) begin
      step(b, 1'b0, 1'b0, 1'b0, 1'b0);
      step(b, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    bus.btn = '0;
    bus.hit = 1'b0;
    bus.miss = 1'b0;
    bus.all_cleared = 1'b0;
    bus.refr_tick = 1'b0;
    reset = 1'b1;

    vecs[0] = '{5'h01, 1'b0, 1'b0, 1'b0, 1'b0, ST_PLAY, 0, 2'd3, 1'b0};
    for (int i = 1; i <= 12; i++) begin
      vecs[i] = '{5'h00, 1'b1, 1'b0, 1'b0, 1'b0, ST_PLAY, i, 2'd3, 1'b0};
    end
    vecs[13] = '{5'h00, 1'b0, 1'b1, 1'b0, 1'b0, ST_NEWBALL, 12, 2'd2, 1'b1};
    vecs[14] = '{5'h00, 1'b1, 1'b0, 1'b0, 1'b0, ST_NEWBALL, 12, 2'd2, 1'b1};
    vecs[15] = '{5'h00, 1'b0, 1'b1, 1'b0, 1'b0, ST_NEWBALL, 12, 2'd2, 1'b1};
    vecs[16] = '{5'h00, 1'b0, 1'b0, 1'b1, 1'b0, ST_NEWBALL, 12, 2'd2, 1'b1};
    vecs[17] = '{5'h10, 1'b0, 1'b0, 1'b0, 1'b0, ST_NEWBALL, 12, 2'd2, 1'b1};
    vecs[18] = '{5'h00, 1'b1, 1'b1, 1'b1, 1'b0, ST_NEWBALL, 12, 2'd2, 1'b1};

    #1;
    check_out("reset", ST_NEWGAME, 0, 2'd3, 1'b1);
    check("reset.timer_up", 32'(bus.timer_up), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // T2, start of T3 and T6 in NEWBALL
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].btn, vecs[i].hit, vecs[i].miss, vecs[i].ac, vecs[i].tick);
      check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].score, vecs[i].balls,
                vecs[i].still);
    end

    // T3: btn held across the whole delay
    for (int k = 1; k <= 120; k++) begin
      step(5'h04, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("hold%0d.state", k), 32'(bus.game_state), 32'(ST_NEWBALL));
      check($sformatf("hold%0d.timer_up", k), 32'(bus.timer_up), 32'(k == 120));
      if (k < 120) step(5'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(5'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("hold.release", ST_PLAY, 12, 2'd2, 1'b0);

    step(5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("miss2", ST_NEWBALL, 12, 2'd1, 1'b1);
    run_ticks(120, 5'h00);
    check_out("nb2.wait", ST_NEWBALL, 12, 2'd1, 1'b1);
    check("nb2.timer_up", 32'(bus.timer_up), 32'd1);
    step(5'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("nb2.go", ST_PLAY, 12, 2'd1, 1'b0);

    // T4: last ball lost with a simultaneous hit
    step(5'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check_out("over", ST_OVER, 13, 2'd0, 1'b1);
    check("over.timer_up", 32'(bus.timer_up), 32'd0);
    step(5'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("over.hit", ST_OVER, 13, 2'd0, 1'b1);
    step(5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out("over.miss", ST_OVER, 13, 2'd0, 1'b1);
    step(5'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("over.ac", ST_OVER, 13, 2'd0, 1'b1);
    run_ticks(119, 5'h1f);
    check_out("over.119", ST_OVER, 13, 2'd0, 1'b1);
    check("over.119.timer_up", 32'(bus.timer_up), 32'd0);
    step(5'h1f, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out("over.120", ST_OVER, 13, 2'd0, 1'b1);
    check("over.120.timer_up", 32'(bus.timer_up), 32'd1);
    step(5'h1f, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("over.exit", ST_NEWGAME, 13, 2'd0, 1'b1);
    step(5'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("game2", ST_PLAY, 0, 2'd3, 1'b0);

    // T5: saturation at 99, then all_cleared beats miss
    for (int i = 0; i < 98; i++) step(5'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("s98", ST_PLAY, 98, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(5'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check_out($sformatf("sat%0d", i), ST_PLAY, 99, 2'd3, 1'b0);
    end
    step(5'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    check_out("win", ST_WIN, 99, 2'd3, 1'b1);
    run_ticks(120, 5'h00);
    check_out("win.wait", ST_WIN, 99, 2'd3, 1'b1);
    step(5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("win.exit", ST_NEWGAME, 99, 2'd3, 1'b1);

    // T1: asynchronous reset mid-PLAY with score 37 and a ball lost
    step(5'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(120, 5'h00);
    step(5'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_score = 0;
    for (int i = 0; i < 37; i++) begin
      step(5'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_score++;
    end
    check_out("pre_reset", ST_PLAY, exp_score, 2'd2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", ST_NEWGAME, 0, 2'd3, 1'b1);
    check("async_reset.timer_up", 32'(bus.timer_up), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    step(5'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    check_out("post_reset", ST_NEWGAME, 0, 2'd3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
